// File: rtl/round_state_reg.sv
// round_state_reg: WORDS x WORD_W round state register with word merge,
// word rotation, and an up/down round counter with a sticky done flag.
module round_state_reg #(
  parameter int WORD_W    = 32,
  parameter int WORDS     = 4,
  parameter int ROUND_W   = 4,
  parameter int ROUND_MAX = 10
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      clear,
  input  logic                      Load,
  input  logic [WORDS*WORD_W-1:0]   Din,
  input  logic                      word_we,
  input  logic [$clog2(WORDS)-1:0]  word_sel,
  input  logic [WORD_W-1:0]         D_sub,
  input  logic                      rot,
  output logic [WORDS*WORD_W-1:0]   Data_out,
  input  logic                      rnd_load,
  input  logic [ROUND_W-1:0]        rnd_init,
  input  logic                      rnd_en,
  input  logic                      rnd_dir,
  output logic [ROUND_W-1:0]        rnd_out,
  output logic                      rnd_term,
  output logic                      done
);

  localparam int SEL_W = $clog2(WORDS);
  localparam logic [ROUND_W-1:0] RMAX = ROUND_W'(ROUND_MAX);

  logic [WORDS*WORD_W-1:0] r_state;
  logic [WORDS*WORD_W-1:0] w_state_next;
  logic [WORDS-1:0]        w_word_wr;
  logic [ROUND_W-1:0]      r_rnd;
  logic [ROUND_W-1:0]      w_rnd_next;
  logic [ROUND_W-1:0]      w_rnd_step;
  logic [ROUND_W-1:0]      w_term_val;
  logic                    r_done;
  logic                    w_done_next;

  // Per-word next-state: an out-of-range word_sel matches no word, so the
  // write is silently dropped while a concurrent Load still lands.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] w_cur;
      logic [WORD_W-1:0] w_din_word;
      logic [WORD_W-1:0] w_rot_src;
      logic [WORD_W-1:0] w_next_word;

      assign w_word_wr[gi] = word_we && (word_sel == SEL_W'(gi));
      assign w_cur         = r_state[gi*WORD_W +: WORD_W];
      assign w_din_word    = Din[gi*WORD_W +: WORD_W];
      assign w_rot_src     = r_state[((gi + 1) % WORDS)*WORD_W +: WORD_W];

      // Priority: clear > load/merge > rotate > hold.
      always_comb begin
        w_next_word = w_cur;
        if (clear) begin
          w_next_word = '0;
        end else if (Load || word_we) begin
          w_next_word = Load ? w_din_word : w_cur;
          if (w_word_wr[gi]) begin
            w_next_word = D_sub;
          end
        end else if (rot) begin
          w_next_word = w_rot_src;
        end
      end

      assign w_state_next[gi*WORD_W +: WORD_W] = w_next_word;
    end
  endgenerate

  // Saturating single step in the requested direction; above RMAX counting up holds.
  always_comb begin
    w_rnd_step = r_rnd;
    w_term_val = rnd_dir ? '0 : RMAX;
    if (rnd_dir) begin
      if (r_rnd != '0) begin
        w_rnd_step = r_rnd - ROUND_W'(1);
      end
    end else begin
      if (r_rnd < RMAX) begin
        w_rnd_step = r_rnd + ROUND_W'(1);
      end
    end
  end

  // Counter and sticky done next-state: clear > rnd_load > rnd_en > hold.
  always_comb begin
    w_rnd_next  = r_rnd;
    w_done_next = r_done;
    if (clear) begin
      w_rnd_next  = RMAX;
      w_done_next = 1'b0;
    end else if (rnd_load) begin
      w_rnd_next  = rnd_init;
      w_done_next = 1'b0;
    end else if (rnd_en) begin
      w_rnd_next = w_rnd_step;
      if (w_rnd_step == w_term_val) begin
        w_done_next = 1'b1;
      end
    end
  end

  // State, counter and done registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= '0;
      r_rnd   <= RMAX;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rnd   <= w_rnd_next;
      r_done  <= w_done_next;
    end
  end

  assign Data_out = r_state;
  assign rnd_out  = r_rnd;
  assign done     = r_done;
  assign rnd_term = (r_rnd == w_term_val);

endmodule

// File: tb/tb_round_state_reg.sv
// Directed, table-driven bench for round_state_reg (default build plus a WORDS=3 build).
module tb_round_state_reg;

  logic clk;
  logic rst_n;

  // Default build (4 x 32)
  logic         clear, load, we, rot, rl, en, dir;
  logic [127:0] din;
  logic [1:0]   sel;
  logic [31:0]  dsub;
  logic [3:0]   ri;
  logic [127:0] data_out;
  logic [3:0]   rnd_out;
  logic         rnd_term, done_o;

  // WORDS=3 build (3 x 8)
  logic         b_clear, b_load, b_we, b_rot, b_rl, b_en, b_dir;
  logic [23:0]  b_din;
  logic [1:0]   b_sel;
  logic [7:0]   b_dsub;
  logic [3:0]   b_ri;
  logic [23:0]  b_data;
  logic [3:0]   b_rnd;
  logic         b_term, b_done;

  int errors = 0;
  int checks = 0;

  round_state_reg dut (
    .CLK(clk), .RESET(rst_n), .clear(clear), .Load(load), .Din(din),
    .word_we(we), .word_sel(sel), .D_sub(dsub), .rot(rot), .Data_out(data_out),
    .rnd_load(rl), .rnd_init(ri), .rnd_en(en), .rnd_dir(dir),
    .rnd_out(rnd_out), .rnd_term(rnd_term), .done(done_o)
  );

  round_state_reg #(.WORD_W(8), .WORDS(3), .ROUND_W(4), .ROUND_MAX(10)) dut3 (
    .CLK(clk), .RESET(rst_n), .clear(b_clear), .Load(b_load), .Din(b_din),
    .word_we(b_we), .word_sel(b_sel), .D_sub(b_dsub), .rot(b_rot), .Data_out(b_data),
    .rnd_load(b_rl), .rnd_init(b_ri), .rnd_en(b_en), .rnd_dir(b_dir),
    .rnd_out(b_rnd), .rnd_term(b_term), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         clr, ld;
    logic [127:0] din;
    logic         we;
    logic [1:0]   sel;
    logic [31:0]  dsub;
    logic         rot, rl;
    logic [3:0]   ri;
    logic         en, dir;
    logic [127:0] e_data;
    logic [3:0]   e_rnd;
    logic         e_term, e_done;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t sv(string n, logic c, logic l, logic [127:0] d, logic w,
                              logic [1:0] s, logic [31:0] ds, logic r, logic rld,
                              logic [3:0] rin, logic e, logic dr, logic [127:0] ed,
                              logic [3:0] er, logic et, logic edn);
    vec_t v;
    v.name = n; v.clr = c; v.ld = l; v.din = d; v.we = w; v.sel = s; v.dsub = ds;
    v.rot = r; v.rl = rld; v.ri = rin; v.en = e; v.dir = dr;
    v.e_data = ed; v.e_rnd = er; v.e_term = et; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clear = 0; load = 0; din = '0; we = 0; sel = 0; dsub = 0; rot = 0;
    rl = 0; ri = 0; en = 0; dir = 0;
  endtask

  task automatic apply(int i);
    @(negedge clk);
    clear = vecs[i].clr; load = vecs[i].ld; din = vecs[i].din; we = vecs[i].we;
    sel = vecs[i].sel; dsub = vecs[i].dsub; rot = vecs[i].rot; rl = vecs[i].rl;
    ri = vecs[i].ri; en = vecs[i].en; dir = vecs[i].dir;
    @(posedge clk);
    #1;
    $display("vec %0d %s: data=%h rnd=%0d term=%0b done=%0b",
             i, vecs[i].name, data_out, rnd_out, rnd_term, done_o);
    chk({vecs[i].name, ".data"}, data_out, vecs[i].e_data);
    chk({vecs[i].name, ".rnd"},  128'(rnd_out), 128'(vecs[i].e_rnd));
    chk({vecs[i].name, ".term"}, 128'(rnd_term), 128'(vecs[i].e_term));
    chk({vecs[i].name, ".done"}, 128'(done_o), 128'(vecs[i].e_done));
  endtask

  task automatic b_step(string name, logic l, logic [23:0] d, logic w, logic [1:0] s,
                        logic [7:0] ds, logic r, logic [23:0] exp);
    @(negedge clk);
    b_load = l; b_din = d; b_we = w; b_sel = s; b_dsub = ds; b_rot = r;
    @(posedge clk);
    #1;
    $display("w3 %s: data=%h", name, b_data);
    chk(name, 128'(b_data), 128'(exp));
  endtask

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] P    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] M    = 128'h00112233_DEADBEEF_8899AABB_CCDDEEFF;
  localparam logic [127:0] D11  = 128'hA5A5A5A5_DEADBEEF_8899AABB_12345678;

  initial begin
    // Vectors: name, clr, ld, din, we, sel, dsub, rot, rl, ri, en, dir | data, rnd, term, done
    vecs[0]  = sv("ld_ones", 0,1,ONES,0,0,0,0,1,4'd1,0,0, ONES,4'd1,0,0);
    vecs[1]  = sv("dn_to0",  0,0,0,0,0,0,0,0,0,1,1,       ONES,4'd0,1,1);
    vecs[2]  = sv("up_1",    0,0,0,0,0,0,0,0,0,1,0,       ONES,4'd1,0,1);
    vecs[3]  = sv("up_2",    0,0,0,0,0,0,0,0,0,1,0,       ONES,4'd2,0,1);
    vecs[4]  = sv("up_3",    0,0,0,0,0,0,0,0,0,1,0,       ONES,4'd3,0,1);
    vecs[5]  = sv("ld_merge",0,1,P,1,2'd2,32'hDEADBEEF,0,0,0,0,0, M,4'd10,1,0);
    vecs[6]  = sv("rot1",    0,0,0,0,0,0,1,0,0,0,0, 128'hCCDDEEFF_00112233_DEADBEEF_8899AABB,4'd10,1,0);
    vecs[7]  = sv("rot2",    0,0,0,0,0,0,1,0,0,0,0, 128'h8899AABB_CCDDEEFF_00112233_DEADBEEF,4'd10,1,0);
    vecs[8]  = sv("rot3",    0,0,0,0,0,0,1,0,0,0,0, 128'hDEADBEEF_8899AABB_CCDDEEFF_00112233,4'd10,1,0);
    vecs[9]  = sv("rot4",    0,0,0,0,0,0,1,0,0,0,0, M,4'd10,1,0);
    vecs[10] = sv("rot_we",  0,0,0,1,2'd0,32'h12345678,1,0,0,0,0,
                  128'h00112233_DEADBEEF_8899AABB_12345678,4'd10,1,0);
    vecs[11] = sv("we_w3",   0,0,0,1,2'd3,32'hA5A5A5A5,0,0,0,0,0, D11,4'd10,1,0);
    vecs[12] = sv("rl10_dn", 0,0,0,0,0,0,0,1,4'd10,0,1, D11,4'd10,0,0);
    for (int k = 0; k < 10; k++)
      vecs[13+k] = sv("dn_step",0,0,0,0,0,0,0,0,0,1,1, D11,4'(9-k),(k==9),(k==9));
    vecs[23] = sv("dn_sat",  0,0,0,0,0,0,0,0,0,1,1, D11,4'd0,1,1);
    vecs[24] = sv("rl8_up",  0,0,0,0,0,0,0,1,4'd8,0,0, D11,4'd8,0,0);
    vecs[25] = sv("up_9",    0,0,0,0,0,0,0,0,0,1,0, D11,4'd9,0,0);
    vecs[26] = sv("up_10",   0,0,0,0,0,0,0,0,0,1,0, D11,4'd10,1,1);
    vecs[27] = sv("up_sat",  0,0,0,0,0,0,0,0,0,1,0, D11,4'd10,1,1);
    vecs[28] = sv("clr_rl",  1,1,P,0,0,0,0,1,4'd5,0,0, 128'd0,4'd10,1,0);
    vecs[29] = sv("rl15",    0,0,0,0,0,0,0,1,4'd15,0,0, 128'd0,4'd15,0,0);
    vecs[30] = sv("up_above",0,0,0,0,0,0,0,0,0,1,0, 128'd0,4'd15,0,0);

    idle();
    b_clear = 0; b_load = 0; b_din = 0; b_we = 0; b_sel = 0; b_dsub = 0; b_rot = 0;
    b_rl = 0; b_ri = 0; b_en = 0; b_dir = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.data", data_out, 128'd0);
    chk("rst.rnd",  128'(rnd_out), 128'd10);
    chk("rst.done", 128'(done_o), 128'd0);
    chk("rst.term", 128'(rnd_term), 128'd1);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 5; i++) apply(i);

    // Asynchronous reset between edges: takes effect before the next edge
    #2;
    rst_n = 0;
    #1;
    $display("async reset: data=%h rnd=%0d done=%0b", data_out, rnd_out, done_o);
    chk("arst.data", data_out, 128'd0);
    chk("arst.rnd",  128'(rnd_out), 128'd10);
    chk("arst.done", 128'(done_o), 128'd0);
    @(negedge clk);
    idle();
    rst_n = 1;

    for (int i = 5; i < 31; i++) apply(i);

    // rnd_term follows rnd_dir combinationally
    @(negedge clk);
    idle();
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    #1;
    chk("term.up", 128'(rnd_term), 128'd1);
    dir = 1;
    #1;
    $display("term dir flip: rnd=%0d term=%0b", rnd_out, rnd_term);
    chk("term.dn", 128'(rnd_term), 128'd0);
    dir = 0;

    // WORDS=3 build: out-of-range word_sel drops the word write
    b_step("w3.load",     1, 24'h112233, 0, 2'd0, 8'h00, 0, 24'h112233);
    b_step("w3.oor_we",   0, 24'h000000, 1, 2'd3, 8'hFF, 0, 24'h112233);
    b_step("w3.oor_ld",   1, 24'hAABBCC, 1, 2'd3, 8'hFF, 0, 24'hAABBCC);
    b_step("w3.we2",      0, 24'h000000, 1, 2'd2, 8'h44, 0, 24'h44BBCC);
    b_step("w3.rot",      0, 24'h000000, 0, 2'd0, 8'h00, 1, 24'hCC44BB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_state_reg.md
# round_state_reg

Parametrised AES-style round state register with a built-in round counter. It supersedes the separate fixed 128-bit word-merge register, 4-bit up/down counters and 1-bit sticky flag. It holds a WORDS×WORD_W state and supports full load, single-word merge, combined load-plus-merge and word rotation. An up/down round counter with configurable limits and a sticky done flag sits alongside, so the cipher control FSM drives one block per datapath.

## Interface
Parameters:
- WORD_W, 32, bits per word
- WORDS, 4, words in state (≥2); word 0 occupies bits [WORD_W-1:0]
- ROUND_W, 4, round counter width
- ROUND_MAX, 10, terminal value when counting up (≤ 2^ROUND_W − 1)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of state, counter, done
- Load  in  1  load full state from Din
- Din  in  WORDS*WORD_W  full-state input
- word_we  in  1  write D_sub into word word_sel
- word_sel  in  $clog2(WORDS)  target word index
- D_sub  in  WORD_W  word data
- rot  in  1  rotate state by one word
- Data_out  out  WORDS*WORD_W  registered state
- rnd_load  in  1  load counter from rnd_init
- rnd_init  in  ROUND_W  counter load value
- rnd_en  in  1  step counter
- rnd_dir  in  1  0 = up, 1 = down
- rnd_out  out  ROUND_W  registered counter
- rnd_term  out  1  combinational: counter at terminal value for current rnd_dir (ROUND_MAX up, 0 down)
- done  out  1  registered sticky flag

## Operation
- Reset (RESET low, async): Data_out = 0, rnd_out = ROUND_MAX, done = 0. Held while low; first update on the first rising edge after release.
- State path priority per edge: clear > (Load and/or word_we) > rot > hold.
  - clear: Data_out ← 0.
  - Load only: Data_out ← Din.
  - word_we only: word[word_sel] ← D_sub; other words hold.
  - Load and word_we together: Data_out ← Din with word[word_sel] replaced by D_sub.
  - rot: word[i] ← word[(i+1) mod WORDS], so word 0 moves to word WORDS-1. rot is ignored when Load or word_we is active.
- Out-of-range word_sel (≥ WORDS, non-power-of-two WORDS only): the word write is dropped. A simultaneous Load still applies.
- Counter path priority: clear > rnd_load > rnd_en > hold.
  - clear: rnd_out ← ROUND_MAX.
  - rnd_load: rnd_out ← rnd_init.
  - rnd_en, up: +1, saturating at ROUND_MAX. A counter already above ROUND_MAX (via rnd_load) holds.
  - rnd_en, down: −1, saturating at 0.
- done:
  - Cleared by clear or rnd_load.
  - Set on the edge where rnd_en is active and the next counter value equals the terminal value for the current rnd_dir.
  - Otherwise holds. rnd_en at saturation keeps done = 1.
- State path and counter path are independent; both may update on the same edge.

## Timing
- All outputs except rnd_term are registered; single-cycle latency from the qualifying edge.
- rnd_term is purely combinational from rnd_out and rnd_dir; it may change within the same cycle as rnd_dir.
- No handshake; control inputs are sampled every edge and must be stable around the CLK edge.
- RESET asserted mid-operation: all registers go to reset values immediately, independent of CLK. Any in-flight Load or step is lost.
- Throughput: one state operation and one counter operation per cycle, back-to-back without restriction.

## Test plan
- Reset with Data_out = all-ones, rnd_out = 3, done = 1; pull RESET low between edges -> Data_out = 0, rnd_out = 10, done = 0 immediately, before the next edge.
- Load Din = 0x00112233_44556677_8899AABB_CCDDEEFF with word_we=1, word_sel=2, D_sub=0xDEADBEEF -> Data_out = 0x00112233_DEADBEEF_8899AABB_CCDDEEFF next cycle.
- From that state, rot for 4 consecutive cycles -> after 1 cycle, word 3 = 0xCCDDEEFF and word 0 = 0x8899AABB; after 4 cycles, state equals the starting value. rot with word_we in the same cycle -> word write only.
- rnd_load rnd_init=10, then rnd_dir=1 and rnd_en for 10 cycles -> rnd_out 9..0; done rises on the edge to 0; rnd_term = 1. An 11th step -> rnd_out stays 0, done stays 1.
- rnd_load 8, rnd_dir=0, rnd_en for 3 cycles -> 9, 10, 10 with done = 1 from the edge to 10. clear together with rnd_load -> rnd_out = 10, done = 0, Data_out = 0.
- WORDS=3 build, word_we with word_sel=3 and Load=0 -> Data_out unchanged. Same with Load=1 -> Data_out = Din.
